dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the pipeline's MEM stage over a valid/ready request channel and a one-cycle response pulse. It replaces the single-cycle data memory so MEM-stage accesses see configurable read/write latency. While a transaction is in flight it holds `busy` high, which the hazard logic uses to freeze the pipeline. Word-addressed storage with alignment and range checking.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data word width; must be 32
- `DEPTH`, 1024, number of storage words; power of two
- `READ_LAT`, 3, cycles from request accept to read response; ≥1
- `WRITE_LAT`, 2, cycles from request accept to write response; ≥1

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  initiator presents a request
- `req_ready`  out  1  responder can accept; request accepted on edge where `req_valid && req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data
- `resp_valid`  out  1  one-cycle pulse, response complete
- `resp_rdata`  out  DATA_W  load data, valid with `resp_valid` on loads; 0 otherwise
- `resp_err`  out  1  valid with `resp_valid`; misaligned or out-of-range access
- `busy`  out  1  transaction accepted and not yet responded

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On accept: latch write flag, word index `req_addr[2 +: log2(DEPTH)]`, wdata; compute error = `req_addr[1:0]!=0` or `req_addr >= 4*DEPTH`. Latch read data from storage at accept (snapshot). Load counter with LAT−1 (LAT = READ_LAT or WRITE_LAT; error accesses use LAT=1). If LAT−1 == 0 go RESP, else WAIT.
- WAIT: decrement counter; when counter reaches 1→0 transition edge, go RESP.
- RESP: `resp_valid`=1 for exactly this cycle; store commits to storage on the edge leaving RESP only if no error; next state IDLE.
- Erroneous store: no storage write. Erroneous load: `resp_rdata`=0.
- `req_valid` ignored outside IDLE; request fields need not be held after accept.
- No response backpressure: initiator must consume the pulse.
- Counter width: `$clog2(max(READ_LAT,WRITE_LAT))+1`.

## Timing
- Reset (rst=0, asynchronous): state IDLE, `req_ready`=1 after release, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0, counter 0. Storage contents not reset.
- Reset during WAIT/RESP: transaction dropped, pending store never commits, no response emitted.
- Accept at edge N → `resp_valid` high during cycle N+LAT (cycle after edge N+LAT−1... i.e. visible LAT cycles after the accept edge); store visible to a load accepted at edge N+LAT+1 or later.
- `busy`=1 from cycle after accept through the RESP cycle inclusive; `req_ready`=!busy.
- Throughput: one transaction per LAT+1 cycles; next accept possible on the edge ending the RESP cycle +1 (IDLE cycle).
- `resp_rdata`/`resp_err` return to 0 in the cycle after RESP.

## Structure
- Package `dmem_pkg`: state enum `dmem_state_t` {IDLE, WAIT, RESP}, constant for word-offset bits (2), helper function for latency selection.
- One sub-module `word_ram`: DEPTH×32 synchronous-write, asynchronous-read array with write enable, index, wdata, rdata. Responder holds FSM, counter, latches, error check.

## Test plan
- Reset then store addr 0x10 data 0xDEADBEEF, later load 0x10 → write resp at accept+2, err=0; load resp at accept+3, rdata=0xDEADBEEF.
- Load 0x12 (misaligned) → resp_valid 1 cycle after accept, err=1, rdata=0; prior word at 0x10 unchanged.
- Store 4*DEPTH (0x1000) data 0x1 → err=1, no word modified (readback 0x0FFC unchanged).
- Hold req_valid high continuously with 3 loads → accepts spaced READ_LAT+1=4 cycles apart, exactly 3 resp pulses, busy never drops between mid-transaction cycles.
- Assert rst low during WAIT of store 0x20←0x55 → no resp_valid, all outputs 0 immediately, subsequent load 0x20 returns old value.
- READ_LAT=1, WRITE_LAT=1 build → every response in cycle after accept, busy high exactly 1 cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_OFF_W = 2;

    // Faulting accesses always complete in a single cycle regardless of direction.
    function automatic int sel_lat(input logic is_write, input logic is_err,
                                   input int read_lat, input int write_lat);
        if (is_err)
            return 1;
        else if (is_write)
            return write_lat;
        return read_lat;
    endfunction

endpackage

// File: rtl/dmem_responder_word_ram.sv
// Word-wide storage array: synchronous write, asynchronous read, no reset.
module word_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with configurable read/write latency; holds busy while a
// transaction is in flight so the pipeline can freeze around it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    dmem_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_p0;
    logic              err_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rdata_p0;

    logic              accept;
    logic [IDX_W-1:0]  req_idx;
    logic              req_err;
    logic [CNT_W-1:0]  lat_m1;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign accept  = req_valid && (state_q == IDLE);
    assign req_idx = req_addr[WORD_OFF_W +: IDX_W];
    // Anything above the top word index is out of range since DEPTH is a power of two.
    assign req_err = (req_addr[WORD_OFF_W-1:0] != '0) ||
                     (req_addr[ADDR_W-1:WORD_OFF_W+IDX_W] != '0);
    assign lat_m1  = CNT_W'(sel_lat(req_write, req_err, READ_LAT, WRITE_LAT) - 1);

    // The single array port reads the incoming request in IDLE and commits the store in RESP.
    assign ram_idx = (state_q == RESP) ? idx_p0 : req_idx;
    assign ram_we  = (state_q == RESP) && wr_p0 && !err_p0;

    word_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_p0),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_p0   <= 1'b0;
            err_p0  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_p0   <= req_write;
                        err_p0  <= req_err;
                        cnt_q   <= lat_m1;
                        state_q <= (lat_m1 == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---- request capture (p0): data only, qualified by state on the way out
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0   <= req_idx;
            wdata_p0 <= req_wdata;
            rdata_p0 <= ram_rdata;
        end
    end

    assign busy       = (state_q != IDLE);
    assign req_ready  = !busy;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_p0;
    assign resp_rdata = (resp_valid && !wr_p0 && !err_p0) ? rdata_p0 : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default-latency instance plus a unit-latency instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready,  resp_valid,  resp_err,  busy;
    logic [31:0] resp_rdata;
    logic        req_ready1, resp_valid1, resp_err1, busy1;
    logic [31:0] resp_rdata1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .READ_LAT(3), .WRITE_LAT(2)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .READ_LAT(1), .WRITE_LAT(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on u0, then follow it to its response and the idle cycle after.
    task automatic txn(input string tag, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input bit exp_err,
                       input logic [31:0] exp_rd);
        int n;
        bit got;
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        check({tag, "/busy_acc"}, 32'(busy), 32'd1);
        n = 1;
        got = 1'b0;
        while (!got && n <= 20) begin
            if (resp_valid) got = 1'b1;
            else begin
                step();
                n++;
            end
        end
        check({tag, "/lat"}, 32'(n), 32'(exp_lat));
        check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "/rdata"}, resp_rdata, exp_rd);
        step();
        check({tag, "/vld_after"}, 32'(resp_valid), 32'd0);
        check({tag, "/busy_after"}, 32'(busy), 32'd0);
        check({tag, "/rdata_after"}, resp_rdata, 32'd0);
        check({tag, "/err_after"}, 32'(resp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] addrs [3];
        int acc [3];
        logic [31:0] rd [3];
        int k, nresp, nbusy;

        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) step();
        check("rst/resp_valid", 32'(resp_valid), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/rdata", resp_rdata, 32'd0);
        check("rst/err", 32'(resp_err), 32'd0);
        check("rst/busy1", 32'(busy1), 32'd0);
        rst = 1'b1;
        step();
        check("rst/ready", 32'(req_ready), 32'd1);

        txn("st10",     1'b1, 32'h10,   32'hDEADBEEF, 2, 1'b0, 32'h0);
        txn("ld10",     1'b0, 32'h10,   32'h0,        3, 1'b0, 32'hDEADBEEF);
        txn("ld12_mis", 1'b0, 32'h12,   32'h0,        1, 1'b1, 32'h0);
        txn("st11_mis", 1'b1, 32'h11,   32'hFFFFFFFF, 1, 1'b1, 32'h0);
        txn("ld10_b",   1'b0, 32'h10,   32'h0,        3, 1'b0, 32'hDEADBEEF);
        txn("stFFC",    1'b1, 32'hFFC,  32'h12345678, 2, 1'b0, 32'h0);
        txn("st000",    1'b1, 32'h0,    32'hA5A5A5A5, 2, 1'b0, 32'h0);
        txn("st1000",   1'b1, 32'h1000, 32'h1,        1, 1'b1, 32'h0);
        txn("ldFFC",    1'b0, 32'hFFC,  32'h0,        3, 1'b0, 32'h12345678);
        txn("ld000",    1'b0, 32'h0,    32'h0,        3, 1'b0, 32'hA5A5A5A5);

        // Three loads with req_valid held high throughout.
        addrs[0] = 32'h10; addrs[1] = 32'hFFC; addrs[2] = 32'h0;
        k = 0; nresp = 0; nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            if (k < 3) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = addrs[k];
            end else begin
                req_valid = 1'b0; req_addr = '0;
            end
            if (req_ready && req_valid) begin
                acc[k] = c;
                k++;
            end
            step();
            if (busy) nbusy++;
            if (resp_valid) begin
                if (nresp < 3) rd[nresp] = resp_rdata;
                nresp++;
            end
        end
        req_valid = 1'b0;
        check("b2b/accepts", 32'(k), 32'd3);
        check("b2b/gap01", 32'(acc[1] - acc[0]), 32'd4);
        check("b2b/gap12", 32'(acc[2] - acc[1]), 32'd4);
        check("b2b/nresp", 32'(nresp), 32'd3);
        check("b2b/busy_cycles", 32'(nbusy), 32'd9);
        check("b2b/rd0", rd[0], 32'hDEADBEEF);
        check("b2b/rd1", rd[1], 32'h12345678);
        check("b2b/rd2", rd[2], 32'hA5A5A5A5);
        repeat (3) step();

        // Reset while a store sits in WAIT.
        txn("st20_old", 1'b1, 32'h20, 32'h11, 2, 1'b0, 32'h0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        check("rstw/busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rstw/busy", 32'(busy), 32'd0);
        check("rstw/resp_valid", 32'(resp_valid), 32'd0);
        check("rstw/ready", 32'(req_ready), 32'd1);
        check("rstw/rdata", resp_rdata, 32'd0);
        nresp = 0;
        repeat (3) begin
            step();
            if (resp_valid) nresp++;
        end
        check("rstw/no_resp", 32'(nresp), 32'd0);
        rst = 1'b1;
        step();
        txn("ld20", 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h11);

        // Unit-latency instance: response in the cycle after accept, busy for one cycle.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h77;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        check("u1st/resp_valid", 32'(resp_valid1), 32'd1);
        check("u1st/busy", 32'(busy1), 32'd1);
        check("u1st/err", 32'(resp_err1), 32'd0);
        step();
        check("u1st/resp_after", 32'(resp_valid1), 32'd0);
        check("u1st/busy_after", 32'(busy1), 32'd0);
        repeat (3) step();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
        step();
        req_valid = 1'b0; req_addr = '0;
        check("u1ld/resp_valid", 32'(resp_valid1), 32'd1);
        check("u1ld/rdata", resp_rdata1, 32'h77);
        check("u1ld/busy", 32'(busy1), 32'd1);
        step();
        check("u1ld/busy_after", 32'(busy1), 32'd0);
        check("u1ld/rdata_after", resp_rdata1, 32'd0);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
